dec_seq: RTL
============

# dec_seq

Registered, flow-controlled successor to the combinational instruction decoder. It decodes one 16-bit instruction per accepted handshake and evaluates branch conditions against the ALU flags. It holds the pipeline during data-memory operations and latches HALT and illegal-opcode states. It sits between instruction fetch and the register file/ALU/data-memory stage. Control outputs are registered, with generic datapath width and a memory-timeout watchdog.

## Interface
- DW, 16: datapath width; immediates are extended to DW bits (DW ≥ 16).
- MEM_TMO, 15: cycles to wait for dm_ack before raising fault; 0 disables the watchdog.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- inst  in  16  instruction word.
- inst_vld  in  1  inst is valid.
- inst_rdy  out  1  decoder accepts inst this cycle.
- ze, ca, sg  in  1 each  zero/carry/sign flags, sampled in the accept cycle.
- dm_ack  in  1  data memory completed the current LM/SM.
- h, we, pcwe, pcs, dmwe, dms, dstb  out  1 each  halt, reg write, PC write, PC-relative select, memory write, memory select, dstb strobe.
- wad, ra, rb  out  2 each  write/read register addresses.
- op  out  3  ALU op (ADD=0, SUB=1, THB=2, ASL=3, RSL=4, RSR=5, NAD=6, XOR=7).
- liop  out  2  immediate mode (THU=0, IMM=1, LIL=2, LIH=3).
- iv  out  DW  extended immediate.
- out_vld  out  1  control bundle valid, one cycle per instruction.
- flush  out  1  one-cycle pulse: taken branch, discard fetched-but-unaccepted word.
- fault  out  1  sticky illegal-opcode/timeout indicator.

## Operation
- FSM states: RUN, MEMW, HALT, FAULT. Reset → RUN.
- RUN:
  - inst_rdy=1.
  - On inst_vld, decode into output registers and assert out_vld for one cycle.
- Decoded set (bit 15 leftmost):
  - 000000…0 NOP: dstb=1.
  - 000000…1 HALT: h=1, go to HALT.
  - 000010 rw F op ra rb: CAL. we=1, wad=[9:8], op=[6:4], ra=[3:2], rb=[1:0]; dstb=F.
  - 001# rw ra im8: ALU op with immediate. we=1, op=ADD if #=0 else SUB, liop=IMM, iv=zero-extended im8.
  - 0101 1 1 ff im8 (p=bit12): PC-relative branch. op=ADD, liop=IMM, iv=sign-extended im8. If taken: pcwe=pcs=1 and flush=1.
  - 010p0*ff im8: absolute branch. liop=IMM, iv=sign-extended im8. If taken: pcwe=1, pcs=0, flush=1.
  - 1000 rw 1x im8: LIL (bit8=0) or LIH (bit8=1). we=1, wad=rb=rw, liop=LIL/LIH, iv=im8 zero-extended.
  - 1010 rw ra im8: LM. dms=1, we=1, wad=rw, op=ADD, liop=IMM, iv=sign-extended; go to MEMW.
  - 1011 ra rb im8: SM. dms=1, dmwe=1, op=ADD, liop=IMM, iv=sign-extended; go to MEMW.
  - All other encodings: illegal. fault=1, go to FAULT.
- Branch taken condition:
  - ff=0 (UC): always taken.
  - ff=1/2/3: taken when ze/ca/sg equals p.
- MEMW:
  - inst_rdy=0. dms, dmwe, we, wad, ra, rb and iv hold their values.
  - dm_ack → RUN with out_vld=1 for exactly one cycle (the completion beat).
  - Wait counter reaching MEM_TMO without dm_ack → fault=1, FAULT.
- HALT: inst_rdy=0 and h=1 held until reset.
- FAULT: inst_rdy=0, fault=1, all strobes 0, held until reset.

## Timing
- Reset values:
  - all outputs 0, except inst_rdy=1 once rst deasserts.
  - op=THB (2); liop=THU; fault=0; FSM=RUN; watchdog=0.
- Latency: decode outputs are registered and valid the cycle after the accept edge.
- Strobes (we, pcwe, dmwe, dstb, flush) are qualified by out_vld and are 0 whenever out_vld=0, except in MEMW.
- Handshake rules:
  - An instruction is accepted on a rising edge where inst_vld & inst_rdy.
  - Back-to-back accepts are allowed in RUN.
  - inst_rdy falls combinationally in the cycle a memory-op, HALT or illegal word is registered, so no second word is accepted.
- Flush: asserted exactly one cycle, coincident with out_vld of the taken branch.
- dm_ack in the first MEMW cycle completes with 1-cycle wait. dm_ack outside MEMW is ignored.
- rst mid-MEMW aborts the operation; dms/dmwe drop asynchronously.

## Configuration
- DEC_CMP_EN defined:
  - 1111 ra ** im8 decodes as CMP: ra=[11:10], op=SUB, liop=IMM, iv=sign-extended im8, we=0, out_vld=1 (flags update only).
- DEC_CMP_EN undefined: 1111 is illegal → FAULT.

## Structure
- Shared package `pu_pkg`:
  - op codes, liop codes, flag selectors (UC/ZE/CA/SG);
  - FSM state enum;
  - a decoded-control struct type.
- One sub-module, `dec_cond`: combinational flag/polarity → taken evaluation.
- The watchdog counter is inline, width $clog2(MEM_TMO+1).

## Test plan
- Reset, then 0x0000 then 0x0001 → out_vld pulses with dstb=1, then h=1; inst_rdy=0 afterwards, 0x0000 re-offered is not accepted.
- 0x0A26 (CAL w=2, op=2, ra=1, rb=2) → next cycle we=1, wad=2, op=2, ra=1, rb=2; back-to-back 0x2AFF → op=ADD, wad=2, ra=2, iv=0x00FF.
- 0x5DFE with ze=1 → pcwe=pcs=1, flush=1, iv=0xFFFE (DW=16). Same word with ze=0 → pcwe=0, flush=0.
- 0xA6 04 (LM r1=[r2+4]), dm_ack after 3 cycles → dms held 3 cycles, inst_rdy=0, out_vld one cycle on ack, then RUN.
- SM with no dm_ack, MEM_TMO=15 → fault=1 after 15 MEMW cycles, strobes cleared, rst restores RUN.
- 0xF4 10: fault with DEC_CMP_EN undefined. With DEC_CMP_EN: op=SUB, ra=1, iv=0x0010, we=0.

Source files
------------

// File: rtl/pu_pkg.sv
// pu_pkg: shared codes, FSM states and combinational instruction decode for dec_seq.
// Defining DEC_CMP_EN makes the 1111 opcode decode as CMP instead of illegal.
package pu_pkg;
  typedef enum logic [2:0] {ADD, SUB, THB, ASL, RSL, RSR, NAD, XOR} op_e;
  typedef enum logic [1:0] {THU, IMM, LIL, LIH} liop_e;
  typedef enum logic [1:0] {UC, ZE, CA, SG} flag_e;
  typedef enum logic [1:0] {RUN, MEMW, HALT, FAULT} state_e;
  typedef struct packed {
    logic h, we, pcwe, pcs, dmwe, dms, dstb;
    logic [1:0] wad, ra, rb;
    op_e op;
    liop_e liop;
  } out_t;
  typedef struct packed {
    out_t o;
    logic br, p, sx, mem, ill;
    flag_e ff;
    logic [7:0] im;
  } dec_t;
  function automatic dec_t decode(input logic [15:0] i);
    dec_t c;
    c = '0;
    c.o.op = THB;
    c.o.liop = THU;
    c.im = i[7:0];
    if (i[15:10] == 6'b000000) begin
      c.o.h = i[0];
      c.o.dstb = ~i[0];
    end else if (i[15:10] == 6'b000010) begin
      c.o.we = 1'b1;
      c.o.wad = i[9:8];
      c.o.dstb = i[7];
      c.o.op = op_e'(i[6:4]);
      c.o.ra = i[3:2];
      c.o.rb = i[1:0];
    end else if (i[15:13] == 3'b001) begin
      c.o.we = 1'b1;
      c.o.wad = i[11:10];
      c.o.ra = i[9:8];
      c.o.op = i[12] ? SUB : ADD;
      c.o.liop = IMM;
    end else if (i[15:13] == 3'b010 && !(i[11] && !i[10])) begin
      // bit 11 set selects the PC-relative form; pcs here is the "if taken" value
      c.br = 1'b1;
      c.p = i[12];
      c.ff = flag_e'(i[9:8]);
      c.sx = 1'b1;
      c.o.pcs = i[11];
      c.o.liop = IMM;
      if (i[11]) c.o.op = ADD;
    end else if (i[15:12] == 4'b1000 && i[9]) begin
      c.o.we = 1'b1;
      c.o.wad = i[11:10];
      c.o.rb = i[11:10];
      c.o.liop = i[8] ? LIH : LIL;
    end else if (i[15:13] == 3'b101) begin
      c.mem = 1'b1;
      c.sx = 1'b1;
      c.o.dms = 1'b1;
      c.o.dmwe = i[12];
      c.o.we = ~i[12];
      c.o.wad = i[12] ? 2'd0 : i[11:10];
      c.o.ra = i[12] ? i[11:10] : i[9:8];
      c.o.rb = i[12] ? i[9:8] : 2'd0;
      c.o.op = ADD;
      c.o.liop = IMM;
    end
`ifdef DEC_CMP_EN
    else if (i[15:12] == 4'b1111) begin
      c.sx = 1'b1;
      c.o.ra = i[11:10];
      c.o.op = SUB;
      c.o.liop = IMM;
    end
`endif
    else c.ill = 1'b1;
    return c;
  endfunction
endpackage

// File: rtl/dec_cond.sv
// dec_cond: branch-taken evaluation from flag selector, polarity and ALU flags.
module dec_cond import pu_pkg::*; (
  input  logic [1:0] ff,
  input  logic       p,
  input  logic       ze,
  input  logic       ca,
  input  logic       sg,
  output logic       taken
);
  assign taken = (ff == UC) || (p == (ff == ZE ? ze : ff == CA ? ca : sg));
endmodule

// File: rtl/dec_seq.sv
// dec_seq: registered, flow-controlled instruction decoder with branch evaluation,
// data-memory hold and watchdog. Optional CMP opcode via DEC_CMP_EN (see pu_pkg).
module dec_seq import pu_pkg::*; #(
  parameter int DW = 16,
  parameter int MEM_TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   inst,
  input  logic          inst_vld,
  output logic          inst_rdy,
  input  logic          ze,
  input  logic          ca,
  input  logic          sg,
  input  logic          dm_ack,
  output logic          h,
  output logic          we,
  output logic          pcwe,
  output logic          pcs,
  output logic          dmwe,
  output logic          dms,
  output logic          dstb,
  output logic [1:0]    wad,
  output logic [1:0]    ra,
  output logic [1:0]    rb,
  output logic [2:0]    op,
  output logic [1:0]    liop,
  output logic [DW-1:0] iv,
  output logic          out_vld,
  output logic          flush,
  output logic          fault
);
  localparam int CW = MEM_TMO > 0 ? $clog2(MEM_TMO + 1) : 1;
  state_e st, st_n;
  out_t q, q_n;
  dec_t d;
  logic [DW-1:0] iv_n;
  logic [CW-1:0] cnt, cnt_n;
  logic vld_n, flush_n, fault_n, taken, tmo;
  assign d = decode(inst);
  dec_cond u_cond (.ff(d.ff), .p(d.p), .ze, .ca, .sg, .taken);
  assign tmo = MEM_TMO != 0 && cnt == CW'(MEM_TMO - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= RUN;
      q <= '0;
      q.op <= THB;
      iv <= '0;
      cnt <= '0;
      out_vld <= 1'b0;
      flush <= 1'b0;
      fault <= 1'b0;
    end else begin
      st <= st_n;
      q <= q_n;
      iv <= iv_n;
      cnt <= cnt_n;
      out_vld <= vld_n;
      flush <= flush_n;
      fault <= fault_n;
    end
  // strobes only survive a cycle while a memory op is pending
  always_comb begin
    st_n = st;
    q_n = q;
    iv_n = iv;
    cnt_n = '0;
    vld_n = 1'b0;
    flush_n = 1'b0;
    fault_n = fault;
    if (st != MEMW) {q_n.we, q_n.pcwe, q_n.pcs, q_n.dmwe, q_n.dms, q_n.dstb} = '0;
    case (st)
      RUN: if (inst_vld) begin
        if (d.ill) begin
          st_n = FAULT;
          fault_n = 1'b1;
        end else begin
          q_n = d.o;
          q_n.pcwe = d.br & taken;
          q_n.pcs = d.o.pcs & taken;
          flush_n = d.br & taken;
          vld_n = ~d.mem;
          iv_n = d.sx ? {{(DW-8){d.im[7]}}, d.im} : {{(DW-8){1'b0}}, d.im};
          st_n = d.o.h ? HALT : d.mem ? MEMW : RUN;
        end
      end
      MEMW: if (dm_ack) begin
        st_n = RUN;
        vld_n = 1'b1;
        {q_n.dms, q_n.dmwe} = '0;
      end else if (tmo) begin
        st_n = FAULT;
        fault_n = 1'b1;
        {q_n.we, q_n.dms, q_n.dmwe} = '0;
      end else cnt_n = cnt + 1'b1;
      default: ;
    endcase
  end
  assign inst_rdy = st == RUN && !rst;
  assign {h, we, pcwe, pcs, dmwe, dms, dstb} = {q.h, q.we, q.pcwe, q.pcs, q.dmwe, q.dms, q.dstb};
  assign {wad, ra, rb} = {q.wad, q.ra, q.rb};
  assign op = q.op;
  assign liop = q.liop;
endmodule
